spike_address_tx: RTL
=====================

// Module: spike_address_tx
// PURPOSE
//  Transmit side of the spike/source-address interface consumed by the per-neuron MAC units.
//  - Captures one fired-neuron bitmap per timestep.
//  - Serialises every set bit into a 12-bit source address (BASE_ADDR + neuron index).
//  - Queues the addresses in a FIFO and presents them one at a time on a valid/ready port.
//  - Sits between the neuron layer output and the NoC/bus feeding downstream MACs.
// PARAMETERS
//  NUM_NEURONS   10      width of the fired-neuron bitmap
//  ADDR_W        12      source address width; must match the MAC source_address width
//  BASE_ADDR     12'd3   address of neuron index 0; neuron i transmits BASE_ADDR+i
//  FIFO_DEPTH    8       address FIFO entries; power of two, >=2
//  IDLE_ADDR     12'hFFF value driven on source_address when addr_valid=0; never a real neuron address
// PORTS
//  CLK_Tx          in   1            clock; all logic on posedge
//  RST_Tx_n        in   1            reset: synchronous, active-low
//  spike_in        in   NUM_NEURONS  fired bitmap; bit i = neuron i fired this timestep
//  spike_valid     in   1            1-cycle strobe; spike_in is sampled on this cycle
//  source_address  out  ADDR_W       address at the FIFO head
//  addr_valid      out  1            source_address holds a valid spike
//  addr_ready      in   1            downstream accepts; transfer occurs when addr_valid & addr_ready
//  busy            out  1            1 while state==SCAN or FIFO not empty
//  done            out  1            1-cycle pulse when the last address of a batch is accepted
//  drop_err        out  1            sticky; set when a spike_valid strobe is rejected
// BEHAVIOUR
//  Reset (RST_Tx_n=0 at posedge), applied in any state, including mid-SCAN or mid-transfer:
//  - state=IDLE; pending bitmap=0; FIFO emptied.
//  - source_address=IDLE_ADDR; addr_valid=0; busy=0; done=0; drop_err=0.
//  FSM states: IDLE, SCAN.
//  - IDLE: spike_valid=1 and spike_in!=0 -> pending<=spike_in, go to SCAN.
//  - IDLE: spike_valid=1 and spike_in==0 -> stay in IDLE; assert done on the next cycle (empty batch).
//  - SCAN: each cycle with FIFO not full:
//    - select the lowest set bit i of pending;
//    - push BASE_ADDR+i, computed modulo 2^ADDR_W (wraps, no saturation);
//    - clear bit i.
//  - SCAN with FIFO full: stall; pending is unchanged and no bit is lost.
//  - SCAN -> IDLE on the cycle the last pending bit is pushed.
//  - spike_valid while in SCAN: strobe ignored, pending unchanged, drop_err<=1. drop_err clears only on reset.
//  Output port:
//  - Registered, show-ahead FIFO.
//  - Latency: strobe at cycle N -> first push at N+1 -> addr_valid=1 at N+2.
//  - Neurons are transmitted in ascending index order; one address per cycle at best.
//  - While addr_valid=1 and addr_ready=0, source_address and addr_valid are held stable.
//  - addr_valid never deasserts without a transfer.
//  - Push and pop on the same cycle are both performed; occupancy is unchanged.
//  - A push into a full FIFO is impossible (SCAN stalls instead).
//  done: 1-cycle pulse on the cycle after a transfer that leaves the FIFO empty while state==IDLE.
//  busy: combinational OR of (state==SCAN) and (FIFO not empty).
//  Upstream must not strobe spike_valid again until busy=0.
// CONFIGURATION
//  SPIKE_TX_COUNT_EN defined:
//  - adds output port spike_count[15:0];
//  - increments by 1 on each accepted transfer, saturating at 16'hFFFF;
//  - reset to 0.
//  SPIKE_TX_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  T1 Reset: hold RST_Tx_n=0 two cycles mid-SCAN -> addr_valid=0, source_address=12'hFFF, busy=0, drop_err=0.
//  T2 Basic batch: spike_in=10'b00_0001_0101, addr_ready=1 -> addresses 3, 5, 7 on consecutive cycles starting
//     N+2; done pulses once after address 7.
//  T3 Backpressure: spike_in=10'h3FF, addr_ready=0 for 20 cycles ->
//     - FIFO holds 8, SCAN stalls, source_address stays 3;
//     - then addr_ready=1 -> addresses 3..12 in order, none lost or duplicated.
//  T4 Drop: spike_valid again 1 cycle after a 10'h3FF strobe -> drop_err=1 stays set; only the first batch is sent.
//  T5 Empty batch and wrap: spike_in=0 -> done pulses at N+1 with no addr_valid.
//     With BASE_ADDR=12'hFFE, spike_in=10'b100 -> address 12'h000.
//  T6 Counter (SPIKE_TX_COUNT_EN): two batches of 3 and 4 spikes -> spike_count=7.

Source files
------------

// File: rtl/spike_address_tx.sv
// ============================================================================
// Module      : spike_address_tx
// Description : Spike/source-address transmitter. Captures one fired-neuron
//               bitmap per timestep. Each set bit becomes the source address
//               BASE_ADDR + index, emitted in ascending index order through a
//               show-ahead address FIFO with a valid/ready output.
//               Optional feature macro: SPIKE_TX_COUNT_EN adds a saturating
//               16-bit count of accepted transfers on port spike_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_address_tx #(
  parameter int                NUM_NEURONS = 10,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'd3,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR   = 12'hFFF
) (
  input  logic                   CLK_Tx,
  input  logic                   RST_Tx_n,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   spike_valid,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   drop_err
`ifdef SPIKE_TX_COUNT_EN
  ,
  output logic [15:0]            spike_count
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                 state;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] pending_cleared;
  logic [IDX_W-1:0]       lowest_idx;
  logic [ADDR_W-1:0]      push_addr;

  logic [ADDR_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   last_pop;

  // Priority encoder: the descending loop lets the lowest set bit win.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) lowest_idx = IDX_W'(i);
    end
  end

  // Handshake, occupancy and address generation; the address wraps modulo 2^ADDR_W.
  always_comb begin
    pending_cleared = pending & (pending - NUM_NEURONS'(1));
    push_addr       = BASE_ADDR + ADDR_W'(lowest_idx);
    fifo_full       = (count == FULL_COUNT);
    fifo_empty      = (count == '0);
    push            = (state == SCAN) && !fifo_full;
    pop             = !fifo_empty && addr_ready;
    last_pop        = pop && !push && (count == (PTR_W + 1)'(1)) && (state == IDLE);
    addr_valid      = !fifo_empty;
    source_address  = fifo_empty ? IDLE_ADDR : fifo_mem[rd_ptr];
    busy            = (state == SCAN) || !fifo_empty;
  end

  // Control FSM: bitmap capture, scan, drop detection and done pulse.
  always_ff @(posedge CLK_Tx) begin
    if (!RST_Tx_n) begin
      state    <= IDLE;
      pending  <= '0;
      done     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      done <= last_pop;
      case (state)
        IDLE: begin
          if (spike_valid) begin
            if (spike_in != '0) begin
              pending <= spike_in;
              state   <= SCAN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (spike_valid) drop_err <= 1'b1;
          if (push) begin
            pending <= pending_cleared;
            if (pending_cleared == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage has no reset so it can map onto register-file resources.
  always_ff @(posedge CLK_Tx) begin
    if (push) fifo_mem[wr_ptr] <= push_addr;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge CLK_Tx) begin
    if (!RST_Tx_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SPIKE_TX_COUNT_EN
  // Saturating count of accepted transfers.
  always_ff @(posedge CLK_Tx) begin
    if (!RST_Tx_n) begin
      spike_count <= '0;
    end else if (pop && (spike_count != 16'hFFFF)) begin
      spike_count <= spike_count + 16'd1;
    end
  end
`else
`endif

endmodule

`default_nettype wire
